// File: rtl/traffic_controller_multi.sv
// traffic_controller_multi: main road plus NUM_SIDE side roads, latched walk phase, reprogrammable tick-based intervals.
// Defining TRAFFIC_NIGHT_FLASH_EN adds the nightMode input and the flashing night state.
module traffic_controller_multi #(
   parameter int NUM_SIDE = 2,
   parameter int TIME_W   = 4,
   parameter int TICK_DIV = 4,
   parameter int T_BASE   = 6,
   parameter int T_EXT    = 3,
   parameter int T_YEL    = 2,
   parameter int T_WALK   = 4,
   parameter int SIDX_W   = (NUM_SIDE > 1) ? $clog2(NUM_SIDE) : 1
) (
   input  logic                clk,
   input  logic                reset,
`ifdef TRAFFIC_NIGHT_FLASH_EN
   input  logic                nightMode,
`endif
   input  logic [NUM_SIDE-1:0] sensor,
   input  logic                walkRequest,
   input  logic                reprogram,
   input  logic [1:0]          extTimeSelector,
   input  logic [TIME_W-1:0]   extTimeValue,
   output logic                Rm,
   output logic                Ym,
   output logic                Gm,
   output logic [NUM_SIDE-1:0] Rs,
   output logic [NUM_SIDE-1:0] Ys,
   output logic [NUM_SIDE-1:0] Gs,
   output logic                W,
   output logic [TIME_W-1:0]   tv,
   output logic [2:0]          st,
   output logic [SIDX_W-1:0]   sel
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   typedef enum logic [2:0] {MG = 3'd0, MY = 3'd1, WALK = 3'd2, SG = 3'd3, SY = 3'd4, FLASH = 3'd5} state_t;
   state_t state, nstate;
   logic [TIME_W-1:0] t_base, t_ext, t_yel, t_walk, tv_r, load_val, wr_val;
   logic [PW-1:0] pre;
   logic [NUM_SIDE-1:0] req, req_clr, side_on;
   logic [SIDX_W-1:0] sel_r, nxt_side, nxt_idx;
   logic wreq, wreq_clr, ext, ext_set, ext_clr, load, tick, expire, sg_go, nxt_found;
`ifdef TRAFFIC_NIGHT_FLASH_EN
   logic flash_on;
`endif
   assign tick   = pre == PW'(TICK_DIV - 1);
   assign expire = tick && tv_r == TIME_W'(1);
   assign wr_val = (extTimeValue == '0) ? TIME_W'(1) : extTimeValue;
   // round-robin: first pending side strictly after sel_r, wrapping back to sel_r last
   always_comb begin
      nxt_side  = sel_r;
      nxt_found = 1'b0;
      nxt_idx   = '0;
      for (int i = 1; i <= NUM_SIDE; i++) begin
         nxt_idx = SIDX_W'((int'(sel_r) + i) % NUM_SIDE);
         if (!nxt_found && req[nxt_idx]) begin
            nxt_found = 1'b1;
            nxt_side  = nxt_idx;
         end
      end
   end
   always_comb begin
      nstate   = state;
      load     = 1'b0;
      load_val = t_base;
      sg_go    = 1'b0;
      wreq_clr = 1'b0;
      ext_set  = 1'b0;
      ext_clr  = 1'b0;
      if (reprogram) begin
         nstate   = MG;
         load     = 1'b1;
         load_val = (extTimeSelector == 2'd0) ? wr_val : t_base;
         ext_clr  = 1'b1;
      end
`ifdef TRAFFIC_NIGHT_FLASH_EN
      else if (state == FLASH) begin
         if (tick && !nightMode) begin
            nstate   = MY;
            load     = 1'b1;
            load_val = t_yel;
         end
      end
`endif
      else if (expire) begin
         load = 1'b1;
         case (state)
            MG: begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
               if (nightMode) nstate = FLASH; else
`endif
               if (|req || wreq) begin
                  nstate   = MY;
                  load_val = t_yel;
               end
            end
            MY: begin
               if (wreq) begin
                  nstate   = WALK;
                  load_val = t_walk;
                  wreq_clr = 1'b1;
               end else if (|req) begin
                  nstate = SG;
                  sg_go  = 1'b1;
               end else nstate = MG;
            end
            WALK: begin
               nstate = (|req) ? SG : MG;
               sg_go  = |req;
            end
            SG: begin
               if (sensor[sel_r] && !ext) begin
                  ext_set  = 1'b1;
                  load_val = t_ext;
               end else begin
                  nstate   = SY;
                  load_val = t_yel;
               end
            end
            SY: begin
               nstate  = MG;
               ext_clr = 1'b1;
            end
            default: nstate = MG;
         endcase
      end
   end
   assign req_clr = sg_go ? NUM_SIDE'(1) << nxt_side : '0;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= MG;
         t_base <= TIME_W'(T_BASE);
         t_ext  <= TIME_W'(T_EXT);
         t_yel  <= TIME_W'(T_YEL);
         t_walk <= TIME_W'(T_WALK);
         tv_r   <= TIME_W'(T_BASE);
         pre    <= '0;
         req    <= '0;
         wreq   <= 1'b0;
         ext    <= 1'b0;
         sel_r  <= '0;
      end else begin
         state  <= nstate;
         t_base <= (reprogram && extTimeSelector == 2'd0) ? wr_val : t_base;
         t_ext  <= (reprogram && extTimeSelector == 2'd1) ? wr_val : t_ext;
         t_yel  <= (reprogram && extTimeSelector == 2'd2) ? wr_val : t_yel;
         t_walk <= (reprogram && extTimeSelector == 2'd3) ? wr_val : t_walk;
         tv_r   <= load ? load_val : (tick && state != FLASH) ? tv_r - TIME_W'(1) : tv_r;
         pre    <= (load || tick) ? '0 : pre + PW'(1);
         req    <= (req & ~req_clr) | sensor;
         wreq   <= (wreq && !wreq_clr) || walkRequest;
         ext    <= ext_set ? 1'b1 : ext_clr ? 1'b0 : ext;
         sel_r  <= sg_go ? nxt_side : sel_r;
      end
   end
`ifdef TRAFFIC_NIGHT_FLASH_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) flash_on <= 1'b1;
      else flash_on <= (state != FLASH) ? 1'b1 : tick ? ~flash_on : flash_on;
   end
`endif
   assign side_on = NUM_SIDE'(1) << sel_r;
   assign Gm = state == MG;
   assign Rm = state == WALK || state == SG || state == SY;
   assign Gs = (state == SG) ? side_on : '0;
   assign Ys = (state == SY) ? side_on : '0;
   assign W  = state == WALK;
`ifdef TRAFFIC_NIGHT_FLASH_EN
   assign Ym = state == MY || (state == FLASH && flash_on);
   assign Rs = (state == FLASH) ? {NUM_SIDE{flash_on}} : ~(Gs | Ys);
`else
   assign Ym = state == MY;
   assign Rs = ~(Gs | Ys);
`endif
   assign tv  = tv_r;
   assign st  = state;
   assign sel = sel_r;
endmodule

// File: tb/tb_traffic_controller_multi.sv
// tb_traffic_controller_multi: directed and random stimulus against a cycles-remaining reference model.
module tb_traffic_controller_multi;
   localparam int N = 2, TW = 4, TD = 4;
   logic clk = 1'b0, reset = 1'b0;
   logic [N-1:0] sensor = '0;
   logic walkRequest = 1'b0, reprogram = 1'b0;
   logic [1:0] extTimeSelector = 2'd0;
   logic [TW-1:0] extTimeValue = '0;
   logic Rm, Ym, Gm, W;
   logic [N-1:0] Rs, Ys, Gs;
   logic [TW-1:0] tv;
   logic [2:0] st;
   logic sel;
   int n_chk = 0, n_fail = 0;
   int m_st, m_left, m_sel, iv[4];
   bit m_ext, m_wreq;
   bit [N-1:0] m_req;

   traffic_controller_multi dut (
      .clk(clk), .reset(reset), .sensor(sensor), .walkRequest(walkRequest),
      .reprogram(reprogram), .extTimeSelector(extTimeSelector), .extTimeValue(extTimeValue),
      .Rm(Rm), .Ym(Ym), .Gm(Gm), .Rs(Rs), .Ys(Ys), .Gs(Gs), .W(W),
      .tv(tv), .st(st), .sel(sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_chk++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic m_reset();
      m_st = 0; m_sel = 0; m_ext = 0; m_wreq = 0; m_req = '0;
      iv[0] = 6; iv[1] = 3; iv[2] = 2; iv[3] = 4;
      m_left = iv[0] * TD;
   endtask

   // an interval of v ticks is modelled as v*TD cycles counted down; expiry is its last cycle
   task automatic m_step();
      int nxt;
      bit [N-1:0] clr;
      bit wclr;
      clr = '0; wclr = 0; nxt = m_sel;
      for (int k = N; k >= 1; k--) if (m_req[(m_sel + k) % N]) nxt = (m_sel + k) % N;
      if (reprogram) begin
         iv[extTimeSelector] = (extTimeValue == 0) ? 1 : int'(extTimeValue);
         m_st = 0; m_ext = 0; m_left = iv[0] * TD;
      end else if (m_left == 1) begin
         case (m_st)
            0: if (m_req != 0 || m_wreq) begin m_st = 1; m_left = iv[2] * TD; end
               else m_left = iv[0] * TD;
            1: if (m_wreq) begin m_st = 2; wclr = 1; m_left = iv[3] * TD; end
               else if (m_req != 0) begin m_st = 3; m_sel = nxt; clr[nxt] = 1; m_left = iv[0] * TD; end
               else begin m_st = 0; m_left = iv[0] * TD; end
            2: if (m_req != 0) begin m_st = 3; m_sel = nxt; clr[nxt] = 1; m_left = iv[0] * TD; end
               else begin m_st = 0; m_left = iv[0] * TD; end
            3: if (sensor[m_sel] && !m_ext) begin m_ext = 1; m_left = iv[1] * TD; end
               else begin m_st = 4; m_left = iv[2] * TD; end
            default: begin m_st = 0; m_ext = 0; m_left = iv[0] * TD; end
         endcase
      end else m_left--;
      m_req = (m_req & ~clr) | sensor;
      m_wreq = (m_wreq && !wclr) || walkRequest;
   endtask

   task automatic check_all(input string ph);
      logic [N-1:0] on, gs, ys;
      on = N'(1) << m_sel;
      gs = (m_st == 3) ? on : '0;
      ys = (m_st == 4) ? on : '0;
      chk({ph, ":st"}, st, m_st);
      chk({ph, ":tv"}, tv, (m_left + TD - 1) / TD);
      chk({ph, ":sel"}, sel, m_sel);
      chk({ph, ":main"}, {Rm, Ym, Gm}, {m_st >= 2, m_st == 1, m_st == 0});
      chk({ph, ":side"}, {Rs, Ys, Gs}, {~(gs | ys), ys, gs});
      chk({ph, ":walk"}, W, m_st == 2);
   endtask

   task automatic cyc(input string ph);
      @(posedge clk);
      m_step();
      #1;
      check_all(ph);
   endtask

   task automatic run_while(input int s, input int want, input string tag);
      int n;
      n = 0;
      while (st == 3'(s) && n < 400) begin
         cyc(tag);
         n++;
      end
      if (want >= 0) chk({tag, ":dur"}, n, want);
   endtask

   initial begin
      m_reset();
      #12;
      chk("rst:st", st, 0);
      chk("rst:lamps", {Gm, Rs, W}, {1'b1, 2'b11, 1'b0});
      chk("rst:tv", tv, 6);
      @(negedge clk);
      reset = 1'b1;
      check_all("rel");
      // sensor[1] pulse: MY 8, SG side 1 for 24, SY 8
      sensor = 2'b10;
      cyc("A");
      sensor = '0;
      run_while(0, -1, "A_mg");
      run_while(1, 8, "A_my");
      chk("A_gs", Gs, 2'b10);
      chk("A_sel", sel, 1);
      run_while(3, 24, "A_sg");
      run_while(4, 8, "A_sy");
      // sensor[0] held: one extension only
      sensor = 2'b01;
      run_while(0, 24, "B_mg");
      run_while(1, 8, "B_my");
      run_while(3, 36, "B_sg");
      sensor = '0;
      run_while(4, 8, "B_sy");
      // walk request plus sensor[1]
      walkRequest = 1'b1;
      sensor = 2'b10;
      cyc("C");
      walkRequest = 1'b0;
      sensor = '0;
      run_while(0, 23, "C_mg");
      run_while(1, 8, "C_my");
      run_while(2, 16, "C_walk");
      chk("C_sel", {st, sel}, {3'd3, 1'b1});
      run_while(3, 24, "C_sg");
      // reprogram base=4 in SY, then yellow=0 (stored as 1)
      cyc("D");
      cyc("D");
      extTimeSelector = 2'd0;
      extTimeValue = 4'd4;
      reprogram = 1'b1;
      cyc("D_rp");
      reprogram = 1'b0;
      chk("D_st_tv", {st, tv}, {3'd0, 4'd4});
      run_while(0, 16, "D_mg");
      extTimeSelector = 2'd2;
      extTimeValue = 4'd0;
      reprogram = 1'b1;
      cyc("D_rp2");
      reprogram = 1'b0;
      run_while(0, 16, "D_mg2");
      run_while(1, 4, "D_my");
      chk("D_sel", sel, 0);
      run_while(3, 16, "D_sg");
      run_while(4, 4, "D_sy");
      // both sensors with sel=0: side 1 first, then side 0
      sensor = 2'b11;
      cyc("E");
      sensor = '0;
      run_while(0, 15, "E_mg");
      run_while(1, 4, "E_my");
      chk("E_sel1", sel, 1);
      run_while(3, 16, "E_sg");
      run_while(4, 4, "E_sy");
      run_while(0, 16, "E_mg2");
      run_while(1, 4, "E_my2");
      chk("E_sel0", sel, 0);
      cyc("E");
      cyc("E");
      cyc("E");
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("F_rst", {st, Gm, Rs, tv, sel}, {3'd0, 1'b1, 2'b11, 4'd6, 1'b0});
      m_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 30; i++) cyc("F_idle");
      for (int i = 0; i < 1500; i++) begin
         sensor = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
         walkRequest = ($urandom_range(0, 59) == 0);
         reprogram = ($urandom_range(0, 99) == 0);
         extTimeSelector = 2'($urandom_range(0, 3));
         extTimeValue = TW'($urandom_range(0, 9));
         cyc("rnd");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
